// File: rtl/mul_run_checker.sv
// mul_run_checker
//   Run controller for the TopLevel core executing the signed-multiply program.
//   For each vector it clears data memory (once per batch), writes two signed
//   W-bit operands big-endian, zeroes the result area, releases the core,
//   times the run until halt, reads back the 2W-bit product and compares it
//   with the locally computed A*B. Repeats for NUM_VEC vectors per go.
//
// Ports
//   CLK, rst_n            clock (rising edge), async active-low reset
//   go                    one-cycle batch start, accepted only in IDLE
//   fixed_en              sampled at go: 1 uses fixed_a/fixed_b, 0 uses LFSR operands
//   fixed_a, fixed_b      fixed signed operands (W bits)
//   core_start            1 holds the core in init, 0 lets it run
//   core_halt             core done flag
//   mem_we/mem_re         data memory write / read enable (never both high)
//   mem_addr              data memory address, 0 when idle
//   mem_wdata/mem_rdata   write byte / read byte (read data valid one cycle after mem_re)
//   busy, done            batch in progress / one-cycle completion pulse
//   pass_cnt, fail_cnt    saturating vector tallies (fail includes timeouts)
//   timeout_flag          sticky timeout indicator, cleared by go
//   last_cycles           RUN length of the most recent vector
//   max_cycles            largest RUN length seen in the batch
//
// Operand bytes live at 1..2B, result bytes at 2B+1..4B, so MEM_AW must be at
// least 5 for W=32.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for go; core held in init
// CLEAR  | zero the whole data memory, one byte per cycle
// LOAD   | write operands A,B then zero the result bytes
// RUN    | core released, counting cycles until halt or timeout
// READ   | pipelined read of the 2B result bytes (2B+1 cycles)
// CHECK  | compare product, update tallies, pick next vector or DONE
// DONE   | one-cycle done pulse, back to IDLE

module mul_run_checker #(
    parameter int          W       = 16,
    parameter int          NUM_VEC = 8,
    parameter int          TIMEOUT = 4096,
    parameter int          MEM_AW  = 8,
    parameter logic [31:0] SEED    = 32'hACE1_1234
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              go,
    input  logic              fixed_en,
    input  logic [W-1:0]      fixed_a,
    input  logic [W-1:0]      fixed_b,
    output logic              core_start,
    input  logic              core_halt,
    output logic              mem_we,
    output logic              mem_re,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        pass_cnt,
    output logic [7:0]        fail_cnt,
    output logic              timeout_flag,
    output logic [31:0]       last_cycles,
    output logic [31:0]       max_cycles
);

    localparam int B  = W / 8;
    localparam int IW = (MEM_AW > 5) ? MEM_AW : 5;

    localparam logic [31:0]   LFSR_MASK  = 32'h8020_0003;
    localparam logic [IW-1:0] CLEAR_LAST = IW'((2 ** MEM_AW) - 1);
    localparam logic [IW-1:0] LOAD_LAST  = IW'(4 * B - 1);
    localparam logic [IW-1:0] READ_LAST  = IW'(2 * B);
    localparam logic [IW-1:0] RES_BASE   = IW'(2 * B + 1);
    localparam logic [7:0]    VEC_LAST   = 8'(NUM_VEC - 1);
    localparam logic [31:0]   TO_LAST    = 32'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_CHECK = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    logic [2:0]     state;
    logic [IW-1:0]  idx;
    logic [7:0]     vec;
    logic [31:0]    lfsr;
    logic           fixed_mode;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [2*W-1:0] load_sr;
    logic [2*W-1:0] res;
    logic [31:0]    cyc;
    logic           first_run;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? LFSR_MASK : 32'h0);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [31:0]    lfsr1, lfsr2;
    logic [W-1:0]   next_a, next_b;
    logic [2*W-1:0] prod;
    logic [31:0]    run_len;
    logic [IW-1:0]  load_addr, read_addr;
    logic           clear_last, vec_last, run_halt, run_to, start_vec;

    assign lfsr1  = lfsr_step(lfsr);
    assign lfsr2  = lfsr_step(lfsr1);
    assign next_a = fixed_mode ? fixed_a : lfsr1[31 -: W];
    assign next_b = fixed_mode ? fixed_b : lfsr2[31 -: W];

    // Both operands sign-extended to 2W so the product is exact at full width.
    assign prod = $signed({{W{op_a[W-1]}}, op_a}) * $signed({{W{op_b[W-1]}}, op_b});

    assign run_len    = cyc + 32'd1;
    assign clear_last = (idx == CLEAR_LAST);
    assign vec_last   = (vec == VEC_LAST);
    // A halt still asserted from the previous vector is not trusted in the first RUN cycle.
    assign run_halt   = !first_run && core_halt;
    assign run_to     = !run_halt && (cyc == TO_LAST);
    assign start_vec  = (state == ST_CLEAR && clear_last) ||
                        (!vec_last && ((state == ST_RUN && run_to) || state == ST_CHECK));

    assign load_addr = idx + IW'(1);
    assign read_addr = idx + RES_BASE;

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        case (state)
            ST_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = idx[MEM_AW-1:0];
            end
            ST_LOAD: begin
                mem_we    = 1'b1;
                mem_addr  = load_addr[MEM_AW-1:0];
                mem_wdata = load_sr[2*W-1 -: 8];
            end
            ST_READ: begin
                if (idx != READ_LAST) begin
                    mem_re   = 1'b1;
                    mem_addr = read_addr[MEM_AW-1:0];
                end
            end
            default: ;
        endcase
    end

    assign core_start = (state != ST_RUN);
    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign done       = (state == ST_DONE);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            vec          <= 8'd0;
            lfsr         <= SEED;
            fixed_mode   <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            load_sr      <= '0;
            res          <= '0;
            cyc          <= 32'd0;
            first_run    <= 1'b0;
            pass_cnt     <= 8'd0;
            fail_cnt     <= 8'd0;
            timeout_flag <= 1'b0;
            last_cycles  <= 32'd0;
            max_cycles   <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        pass_cnt     <= 8'd0;
                        fail_cnt     <= 8'd0;
                        max_cycles   <= 32'd0;
                        timeout_flag <= 1'b0;
                        fixed_mode   <= fixed_en;
                        idx          <= '0;
                        vec          <= 8'd0;
                        state        <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clear_last) begin
                        idx   <= '0;
                        state <= ST_LOAD;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ST_LOAD: begin
                    // Zeros shift in behind the operands, covering the result bytes.
                    load_sr <= load_sr << 8;
                    if (idx == LOAD_LAST) begin
                        idx       <= '0;
                        cyc       <= 32'd0;
                        first_run <= 1'b1;
                        state     <= ST_RUN;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ST_RUN: begin
                    first_run <= 1'b0;
                    if (run_halt || run_to) begin
                        last_cycles <= run_len;
                        if (run_len > max_cycles) max_cycles <= run_len;
                    end
                    if (run_halt) begin
                        idx   <= '0;
                        state <= ST_READ;
                    end else if (run_to) begin
                        fail_cnt     <= sat_inc(fail_cnt);
                        timeout_flag <= 1'b1;
                        idx          <= '0;
                        if (vec_last) begin
                            state <= ST_DONE;
                        end else begin
                            vec   <= vec + 8'd1;
                            state <= ST_LOAD;
                        end
                    end else begin
                        cyc <= cyc + 32'd1;
                    end
                end
                ST_READ: begin
                    // Data for the read issued at idx-1 arrives now.
                    if (idx != '0) res <= {res[2*W-9:0], mem_rdata};
                    if (idx == READ_LAST) state <= ST_CHECK;
                    else                  idx   <= idx + IW'(1);
                end
                ST_CHECK: begin
                    if (res == prod) pass_cnt <= sat_inc(pass_cnt);
                    else             fail_cnt <= sat_inc(fail_cnt);
                    idx <= '0;
                    if (vec_last) begin
                        state <= ST_DONE;
                    end else begin
                        vec   <= vec + 8'd1;
                        state <= ST_LOAD;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (start_vec) begin
                op_a    <= next_a;
                op_b    <= next_b;
                load_sr <= {next_a, next_b};
                if (!fixed_mode) lfsr <= lfsr2;
            end
        end
    end

endmodule

// File: tb/tb_mul_run_checker.sv
// tb_mul_run_checker
//   Drives two instances: a 16-bit, 8-vector, 100-cycle-timeout checker and a
//   32-bit, 2-vector checker. Each has a byte memory with one-cycle read latency
//   and a behavioural core that, halt_at cycles into RUN, writes the product of
//   the operand bytes it finds in memory and raises halt. Halt is left high after
//   a run and dropped after the first RUN cycle of the next vector, so a stale
//   halt is always present at RUN entry.

module tb_mul_run_checker;

    logic CLK = 1'b0;
    logic rst_n;
    always #5 CLK = ~CLK;

    // 16-bit instance
    logic        go0, fixed_en0, start0, we0, re0, busy0, done0, to0;
    logic        halt0 = 1'b0;
    logic [15:0] fa0, fb0;
    logic [7:0]  addr0, wd0, pass0, fail0;
    logic [7:0]  rd0 = 8'h00;
    logic [31:0] last0, max0;

    // 32-bit instance
    logic        go1, fixed_en1, start1, we1, re1, busy1, done1, to1;
    logic        halt1 = 1'b0;
    logic [31:0] fa1, fb1;
    logic [7:0]  addr1, wd1, pass1, fail1;
    logic [7:0]  rd1 = 8'h00;
    logic [31:0] last1, max1;

    mul_run_checker #(.W(16), .NUM_VEC(8), .TIMEOUT(100), .MEM_AW(8)) u_dut0 (
        .CLK(CLK), .rst_n(rst_n), .go(go0), .fixed_en(fixed_en0),
        .fixed_a(fa0), .fixed_b(fb0), .core_start(start0), .core_halt(halt0),
        .mem_we(we0), .mem_re(re0), .mem_addr(addr0), .mem_wdata(wd0),
        .mem_rdata(rd0), .busy(busy0), .done(done0), .pass_cnt(pass0),
        .fail_cnt(fail0), .timeout_flag(to0), .last_cycles(last0), .max_cycles(max0)
    );

    mul_run_checker #(.W(32), .NUM_VEC(2), .MEM_AW(8)) u_dut1 (
        .CLK(CLK), .rst_n(rst_n), .go(go1), .fixed_en(fixed_en1),
        .fixed_a(fa1), .fixed_b(fb1), .core_start(start1), .core_halt(halt1),
        .mem_we(we1), .mem_re(re1), .mem_addr(addr1), .mem_wdata(wd1),
        .mem_rdata(rd1), .busy(busy1), .done(done1), .pass_cnt(pass1),
        .fail_cnt(fail1), .timeout_flag(to1), .last_cycles(last1), .max_cycles(max1)
    );

    logic [7:0]  mem0 [256] = '{default: 8'h00};
    logic [7:0]  mem1 [256] = '{default: 8'h00};
    int          run0 = 0, run1 = 0;
    int          halt_at0 = 50, halt_at1 = 20, corrupt0 = -1;
    int          rec0_n = 0, rl0_n = 0;
    logic [15:0] rec0_a [128];
    logic [15:0] rec0_b [128];
    int          rl0 [128];
    logic [63:0] prod0, prod1;

    always @(posedge CLK) begin
        if (we0) mem0[addr0] <= wd0;
        if (re0) rd0 <= mem0[addr0];
        if (!start0) begin
            run0 <= run0 + 1;
            if (run0 == 0) begin
                rec0_a[rec0_n] <= {mem0[1], mem0[2]};
                rec0_b[rec0_n] <= {mem0[3], mem0[4]};
                rec0_n <= rec0_n + 1;
            end
            if (run0 + 1 == 1) begin
                halt0 <= 1'b0;
            end else if (run0 + 1 == halt_at0 - 1) begin
                prod0 = longint'($signed({mem0[1], mem0[2]})) * longint'($signed({mem0[3], mem0[4]}));
                for (int i = 0; i < 4; i++) mem0[5 + i] <= prod0[8*(3-i) +: 8];
                if (rec0_n - 1 == corrupt0) mem0[8] <= prod0[7:0] ^ 8'hFF;
                halt0 <= 1'b1;
            end
        end else if (run0 != 0) begin
            rl0[rl0_n] <= run0;
            rl0_n <= rl0_n + 1;
            run0 <= 0;
        end
    end

    always @(posedge CLK) begin
        if (we1) mem1[addr1] <= wd1;
        if (re1) rd1 <= mem1[addr1];
        if (!start1) begin
            run1 <= run1 + 1;
            if (run1 + 1 == 1) begin
                halt1 <= 1'b0;
            end else if (run1 + 1 == halt_at1 - 1) begin
                prod1 = longint'($signed({mem1[1], mem1[2], mem1[3], mem1[4]})) *
                        longint'($signed({mem1[5], mem1[6], mem1[7], mem1[8]}));
                for (int i = 0; i < 8; i++) mem1[9 + i] <= prod1[8*(7-i) +: 8];
                halt1 <= 1'b1;
            end
        end else begin
            run1 <= 0;
        end
    end

    int npass = 0, ntotal = 0;
    int dpulses0, dpulses1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        ntotal++;
        assert (obs === exp_v) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic logic [31:0] lfsr_model(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic run_batch0(input int budget);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        dpulses0 = 0;
        go0 = 1'b1;
        @(negedge CLK);
        go0 = 1'b0;
        while (!seen && n < budget) begin
            @(negedge CLK);
            n++;
            if (done0) begin
                dpulses0++;
                seen = 1;
            end
        end
        check("batch0_done_seen", 64'(seen), 64'd1);
        repeat (4) begin
            @(negedge CLK);
            if (done0) dpulses0++;
        end
    endtask

    logic [31:0] st [16];
    logic [63:0] p1;

    initial begin
        rst_n = 1'b0;
        go0 = 1'b0; fixed_en0 = 1'b0; fa0 = 16'h0; fb0 = 16'h0;
        go1 = 1'b0; fixed_en1 = 1'b0; fa1 = 32'h0; fb1 = 32'h0;

        st[0] = lfsr_model(32'hACE1_1234);
        for (int k = 1; k < 16; k++) st[k] = lfsr_model(st[k-1]);

        repeat (3) @(negedge CLK);
        check("rst_core_start", 64'(start0), 64'd1);
        check("rst_busy_done", {busy0, done0}, 64'd0);
        check("rst_mem_if", {we0, re0, addr0, wd0}, 64'd0);
        check("rst_counts", {pass0, fail0, to0}, 64'd0);
        check("rst_cycles", {last0, max0}, 64'd0);
        rst_n = 1'b1;
        @(negedge CLK);

        // LFSR operands, core halts 50 cycles into each run
        run_batch0(4000);
        check("t1_pass", pass0, 8);
        check("t1_fail", fail0, 0);
        check("t1_last", last0, 50);
        check("t1_max", max0, 50);
        check("t1_timeout", to0, 0);
        check("t1_done_pulses", dpulses0, 1);
        check("t1_idle", {busy0, start0}, 64'b01);
        for (int i = 0; i < 8; i++) begin
            check("t1_opa", rec0_a[i], st[2*i][31:16]);
            check("t1_opb", rec0_b[i], st[2*i+1][31:16]);
        end

        // corrupted LSB byte on the fourth vector
        corrupt0 = rec0_n + 3;
        run_batch0(4000);
        corrupt0 = -1;
        check("t3_pass", pass0, 7);
        check("t3_fail", fail0, 1);
        check("t3_timeout", to0, 0);

        // fixed operands
        fixed_en0 = 1'b1; fa0 = 16'h8000; fb0 = 16'h8000;
        run_batch0(4000);
        check("t2a_result", {mem0[5], mem0[6], mem0[7], mem0[8]}, 32'h4000_0000);
        check("t2a_pass", pass0, 8);
        fa0 = 16'h7FFF;
        run_batch0(4000);
        check("t2b_operands", {mem0[1], mem0[2], mem0[3], mem0[4]}, 32'h7FFF_8000);
        check("t2b_result", {mem0[5], mem0[6], mem0[7], mem0[8]}, 32'hC000_8000);
        check("t2b_pass_fail", {pass0, fail0}, {8'd8, 8'd0});
        fixed_en0 = 1'b0;

        // core never halts
        halt_at0 = 0;
        begin
            int base_rl;
            base_rl = rl0_n;
            run_batch0(4000);
            for (int i = 0; i < 8; i++) check("t4_run_len", rl0[base_rl + i], 100);
        end
        check("t4_timeout", to0, 1);
        check("t4_fail", fail0, 8);
        check("t4_pass", pass0, 0);
        check("t4_last", last0, 100);
        check("t4_max", max0, 100);
        halt_at0 = 50;

        // reset in the middle of LOAD, then a fresh batch
        go0 = 1'b1;
        @(negedge CLK);
        go0 = 1'b0;
        begin
            int n;
            n = 0;
            while (!(we0 && addr0 == 8'hFF) && n < 400) begin
                @(negedge CLK);
                n++;
            end
            check("t5_clear_end_seen", 64'(n < 400), 64'd1);
        end
        repeat (3) @(negedge CLK);
        check("t5_mid_load", {we0, addr0}, {1'b1, 8'd3});
        rst_n = 1'b0;
        @(negedge CLK);
        check("t5_rst_core_start", start0, 1);
        check("t5_rst_mem_if", {we0, re0, addr0, wd0, busy0, done0}, 64'd0);
        check("t5_rst_counts", {pass0, fail0, to0}, 64'd0);
        check("t5_rst_cycles", {last0, max0}, 64'd0);
        rst_n = 1'b1;
        @(negedge CLK);
        begin
            int base;
            base = rec0_n;
            run_batch0(4000);
            for (int i = 0; i < 8; i++) begin
                check("t5_opa", rec0_a[base + i], st[2*i][31:16]);
                check("t5_opb", rec0_b[base + i], st[2*i+1][31:16]);
            end
        end
        check("t5_pass", pass0, 8);

        // 32-bit instance, with a go pulse during busy
        dpulses1 = 0;
        go1 = 1'b1;
        @(negedge CLK);
        go1 = 1'b0;
        repeat (10) @(negedge CLK);
        go1 = 1'b1;
        @(negedge CLK);
        go1 = 1'b0;
        begin
            int n;
            n = 0;
            while (dpulses1 == 0 && n < 2000) begin
                @(negedge CLK);
                n++;
                if (done1) dpulses1++;
            end
            check("t6_done_seen", dpulses1, 1);
        end
        repeat (300) begin
            @(negedge CLK);
            if (done1) dpulses1++;
        end
        check("t6_done_pulses", dpulses1, 1);
        check("t6_no_restart", busy1, 0);
        check("t6_pass_fail", {pass1, fail1}, {8'd2, 8'd0});
        check("t6_last", last1, 20);
        check("t6_op_a", {mem1[1], mem1[2], mem1[3], mem1[4]}, st[2]);
        check("t6_op_b", {mem1[5], mem1[6], mem1[7], mem1[8]}, st[3]);
        p1 = longint'($signed(st[2])) * longint'($signed(st[3]));
        check("t6_product", {mem1[9], mem1[10], mem1[11], mem1[12],
                             mem1[13], mem1[14], mem1[15], mem1[16]}, p1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
